// File: rtl/ram_arbiter.sv
// Two-master arbiter for the shared SoC data RAM: round-robin with an M1 burst lock,
// a lock-length limit that bounds M0 starvation, and tagged one-cycle read return.
module ram_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_LOCK = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  m0_req_i,
   input  logic [ADDR_W-1:0]     m0_addr_i,
   input  logic [DATA_W/8-1:0]   m0_we_i,
   input  logic [DATA_W-1:0]     m0_wdata_i,
   output logic                  m0_gnt_o,
   output logic                  m0_rvalid_o,
   output logic [DATA_W-1:0]     m0_rdata_o,
   input  logic                  m1_req_i,
   input  logic [ADDR_W-1:0]     m1_addr_i,
   input  logic [DATA_W/8-1:0]   m1_we_i,
   input  logic [DATA_W-1:0]     m1_wdata_i,
   input  logic                  m1_lock_i,
   output logic                  m1_gnt_o,
   output logic                  m1_rvalid_o,
   output logic [DATA_W-1:0]     m1_rdata_o,
   output logic [DATA_W/8-1:0]   ram_wr_en_o,
   output logic [ADDR_W-1:0]     ram_wr_addr_o,
   output logic [DATA_W-1:0]     ram_wr_data_o,
   output logic                  ram_rd_en_o,
   output logic [ADDR_W-1:0]     ram_rd_addr_o,
   input  logic [DATA_W-1:0]     ram_rd_data_i
);

   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = $clog2(MAX_LOCK + 1);
   localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);

   logic              last_r;
   logic              lock_r;
   logic [CNT_W-1:0]  lock_cnt_r;
   logic              rd_pend_r;
   logic              rd_owner_r;

   logic              gnt0_s;
   logic              gnt1_s;
   logic              forced_s;
   logic              last_nxt_s;
   logic              lock_nxt_s;
   logic [CNT_W-1:0]  cnt_nxt_s;
   logic              pend_nxt_s;
   logic              owner_nxt_s;
   logic [BE_W-1:0]   win_we_s;
   logic [ADDR_W-1:0] win_addr_s;
   logic [DATA_W-1:0] win_wdata_s;

   // State register: arbitration history, lock tracking and the outstanding read tag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_r     <= 1'b1;
         lock_r     <= 1'b0;
         lock_cnt_r <= '0;
         rd_pend_r  <= 1'b0;
         rd_owner_r <= 1'b0;
      end else begin
         last_r     <= last_nxt_s;
         lock_r     <= lock_nxt_s;
         lock_cnt_r <= cnt_nxt_s;
         rd_pend_r  <= pend_nxt_s;
         rd_owner_r <= owner_nxt_s;
      end
   end

   // Grant decision; nothing is honoured while reset is held
   always_comb begin
      gnt0_s   = 1'b0;
      gnt1_s   = 1'b0;
      forced_s = 1'b0;
      if (rst_n) begin
         case ({m0_req_i, m1_req_i})
            2'b10: gnt0_s = 1'b1;
            2'b01: gnt1_s = 1'b1;
            2'b11: begin
               if (lock_r) begin
                  if (lock_cnt_r == LOCK_MAX) begin
                     gnt0_s   = 1'b1;
                     forced_s = 1'b1;
                  end else begin
                     gnt1_s = 1'b1;
                  end
               end else if (last_r) begin
                  gnt0_s = 1'b1;
               end else begin
                  gnt1_s = 1'b1;
               end
            end
            default: begin
               gnt0_s = 1'b0;
               gnt1_s = 1'b0;
            end
         endcase
      end else begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end
   end

   // Next-state: round-robin pointer, lock set/clear, starvation counter, read tag
   always_comb begin
      last_nxt_s  = last_r;
      lock_nxt_s  = lock_r;
      cnt_nxt_s   = lock_cnt_r;
      owner_nxt_s = rd_owner_r;
      if (gnt1_s) begin
         last_nxt_s = 1'b1;
      end else if (gnt0_s) begin
         last_nxt_s = 1'b0;
      end else begin
         last_nxt_s = last_r;
      end
      if (gnt1_s) begin
         lock_nxt_s = m1_lock_i;
      end else if (!m1_req_i || forced_s) begin
         lock_nxt_s = 1'b0;
      end else begin
         lock_nxt_s = lock_r;
      end
      // Only cycles where M0 actually waits on a held lock count toward the limit
      if (!lock_nxt_s) begin
         cnt_nxt_s = '0;
      end else if (lock_r && m0_req_i && !gnt0_s && (lock_cnt_r != LOCK_MAX)) begin
         cnt_nxt_s = lock_cnt_r + CNT_W'(1);
      end else begin
         cnt_nxt_s = lock_cnt_r;
      end
      pend_nxt_s = (gnt0_s && (m0_we_i == '0)) || (gnt1_s && (m1_we_i == '0));
      if (gnt1_s) begin
         owner_nxt_s = 1'b1;
      end else if (gnt0_s) begin
         owner_nxt_s = 1'b0;
      end else begin
         owner_nxt_s = rd_owner_r;
      end
   end

   // Outputs: grants, winner-driven RAM port, and read data steered to its owner
   always_comb begin
      m0_gnt_o      = gnt0_s;
      m1_gnt_o      = gnt1_s;
      win_we_s      = gnt1_s ? m1_we_i    : m0_we_i;
      win_addr_s    = gnt1_s ? m1_addr_i  : m0_addr_i;
      win_wdata_s   = gnt1_s ? m1_wdata_i : m0_wdata_i;
      ram_wr_en_o   = '0;
      ram_wr_addr_o = '0;
      ram_wr_data_o = '0;
      ram_rd_en_o   = 1'b0;
      ram_rd_addr_o = '0;
      if (gnt0_s || gnt1_s) begin
         if (win_we_s != '0) begin
            ram_wr_en_o   = win_we_s;
            ram_wr_addr_o = win_addr_s;
            ram_wr_data_o = win_wdata_s;
         end else begin
            ram_rd_en_o   = 1'b1;
            ram_rd_addr_o = win_addr_s;
         end
      end else begin
         ram_rd_en_o = 1'b0;
      end
      m0_rvalid_o = rd_pend_r && !rd_owner_r;
      m1_rvalid_o = rd_pend_r && rd_owner_r;
      m0_rdata_o  = m0_rvalid_o ? ram_rd_data_i : '0;
      m1_rdata_o  = m1_rvalid_o ? ram_rd_data_i : '0;
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter (MAX_LOCK=4) with a small byte-write RAM model
// producing registered read data one cycle after rd_en.
module tb_ram_arbiter;

   logic        clk;
   logic        rst_n;
   logic        m0_req, m1_req, m1_lock;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic [3:0]  m0_we, m1_we;
   logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic [3:0]  ram_wr_en;
   logic [31:0] ram_wr_addr, ram_wr_data, ram_rd_addr, ram_rd_data;
   logic        ram_rd_en;

   logic [31:0] mem [0:63];
   int          n_checks;
   int          n_fail;
   int          w;

   ram_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_wdata_i(m0_wdata),
      .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
      .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_wdata_i(m1_wdata),
      .m1_lock_i(m1_lock),
      .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
      .ram_wr_en_o(ram_wr_en), .ram_wr_addr_o(ram_wr_addr), .ram_wr_data_o(ram_wr_data),
      .ram_rd_en_o(ram_rd_en), .ram_rd_addr_o(ram_rd_addr), .ram_rd_data_i(ram_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: byte-enabled write, registered read
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (ram_wr_en[b]) mem[ram_wr_addr[7:2]][b*8 +: 8] <= ram_wr_data[b*8 +: 8];
      end
      if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr[7:2]];
   end

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic set_m0(input logic req, input logic [3:0] we, input logic [31:0] addr,
                         input logic [31:0] wdata);
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
   endtask

   task automatic set_m1(input logic req, input logic [3:0] we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic lock);
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_lock = lock;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      ram_rd_data = 32'h0;
      for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + i;
      mem[2] = 32'h1122_3344;

      // Reset held with both masters requesting
      rst_n = 1'b0;
      set_m0(1'b1, 4'hF, 32'h04, 32'h1234_5678);
      set_m1(1'b1, 4'h0, 32'h20, 32'h0, 1'b0);
      @(negedge clk);
      check_eq("rst_gnt0", m0_gnt, 1'b0);
      check_eq("rst_gnt1", m1_gnt, 1'b0);
      check_eq("rst_wr_en", ram_wr_en, 4'h0);
      check_eq("rst_rd_en", ram_rd_en, 1'b0);
      check_eq("rst_rvalid0", m0_rvalid, 1'b0);
      check_eq("rst_rvalid1", m1_rvalid, 1'b0);
      next_cycle();
      rst_n = 1'b1;

      // Contention: both read continuously, M0 wins first
      set_m0(1'b1, 4'h0, 32'h10, 32'h0);
      set_m1(1'b1, 4'h0, 32'h20, 32'h0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         w = k % 2;
         check_eq("cont_gnt0", m0_gnt, (w == 0));
         check_eq("cont_gnt1", m1_gnt, (w == 1));
         check_eq("cont_onehot", m0_gnt & m1_gnt, 1'b0);
         check_eq("cont_rd_addr", ram_rd_addr, (w == 1) ? 32'h20 : 32'h10);
         if (k > 0) begin
            check_eq("cont_rvalid0", m0_rvalid, (w == 1));
            check_eq("cont_rvalid1", m1_rvalid, (w == 0));
            check_eq("cont_rdata", (w == 1) ? m0_rdata : m1_rdata,
                     (w == 1) ? 32'hC0DE_0004 : 32'hC0DE_0008);
         end else begin
            check_eq("cont_rvalid_first", {m0_rvalid, m1_rvalid}, 2'b00);
         end
         next_cycle();
      end

      // M0 full-word write; also collects the last M1 read return
      set_m1(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      set_m0(1'b1, 4'hF, 32'h04, 32'hDEAD_BEEF);
      @(negedge clk);
      check_eq("last_rvalid1", m1_rvalid, 1'b1);
      check_eq("last_rdata1", m1_rdata, 32'hC0DE_0008);
      check_eq("wr_gnt0", m0_gnt, 1'b1);
      check_eq("wr_en", ram_wr_en, 4'hF);
      check_eq("wr_addr", ram_wr_addr, 32'h04);
      check_eq("wr_data", ram_wr_data, 32'hDEAD_BEEF);
      check_eq("wr_no_rd", ram_rd_en, 1'b0);
      next_cycle();
      set_m0(1'b1, 4'h0, 32'h04, 32'h0);
      @(negedge clk);
      check_eq("rd_gnt0", m0_gnt, 1'b1);
      check_eq("rd_en", ram_rd_en, 1'b1);
      check_eq("rd_no_wr", ram_wr_en, 4'h0);
      next_cycle();
      set_m0(1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      check_eq("rb_rvalid0", m0_rvalid, 1'b1);
      check_eq("rb_rdata0", m0_rdata, 32'hDEAD_BEEF);
      check_eq("rb_rvalid1", m1_rvalid, 1'b0);
      check_eq("rb_rdata1", m1_rdata, 32'h0);
      check_eq("idle_gnt", {m0_gnt, m1_gnt, ram_rd_en}, 3'b000);
      check_eq("idle_addr", ram_rd_addr | ram_wr_addr, 32'h0);
      next_cycle();

      // M1 byte write into 0x11223344, then read back
      set_m1(1'b1, 4'h1, 32'h08, 32'h0000_00AA, 1'b0);
      @(negedge clk);
      check_eq("bw_gnt1", m1_gnt, 1'b1);
      check_eq("bw_wr_en", ram_wr_en, 4'h1);
      next_cycle();
      set_m1(1'b1, 4'h0, 32'h08, 32'h0, 1'b0);
      @(negedge clk);
      check_eq("bw_rd_gnt1", m1_gnt, 1'b1);
      next_cycle();
      set_m1(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      check_eq("bw_rvalid1", m1_rvalid, 1'b1);
      check_eq("bw_rdata1", m1_rdata, 32'h1122_33AA);
      check_eq("bw_rvalid0", m0_rvalid, 1'b0);
      next_cycle();

      // Lock limit: M1 takes the lock alone, then M0 waits through 4 locked grants
      set_m1(1'b1, 4'h0, 32'h20, 32'h0, 1'b1);
      @(negedge clk);
      check_eq("lk_take", m1_gnt, 1'b1);
      next_cycle();
      set_m0(1'b1, 4'h0, 32'h10, 32'h0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check_eq("lk_gnt1", m1_gnt, 1'b1);
         check_eq("lk_gnt0", m0_gnt, 1'b0);
         check_eq("lk_cnt", dut.lock_cnt_r, k - 1);
         next_cycle();
      end
      @(negedge clk);
      check_eq("lk_cnt_max", dut.lock_cnt_r, 3'd4);
      check_eq("lk_release_gnt0", m0_gnt, 1'b1);
      check_eq("lk_release_gnt1", m1_gnt, 1'b0);
      next_cycle();
      set_m1(1'b1, 4'h0, 32'h20, 32'h0, 1'b0);
      @(negedge clk);
      check_eq("lk_cnt_clr", dut.lock_cnt_r, 3'd0);
      check_eq("lk_lock_clr", dut.lock_r, 1'b0);
      check_eq("rr_after_gnt1", m1_gnt, 1'b1);
      next_cycle();
      @(negedge clk);
      check_eq("rr_after_gnt0", m0_gnt, 1'b1);
      next_cycle();
      @(negedge clk);
      check_eq("rr_after_gnt1b", m1_gnt, 1'b1);
      next_cycle();

      // Lock end: M1 alone, lock dropped on its third grant
      set_m0(1'b0, 4'h0, 32'h0, 32'h0);
      set_m1(1'b1, 4'h0, 32'h20, 32'h0, 1'b1);
      @(negedge clk);
      check_eq("le_gnt_a", m1_gnt, 1'b1);
      next_cycle();
      @(negedge clk);
      check_eq("le_lock_held", dut.lock_r, 1'b1);
      next_cycle();
      m1_lock = 1'b0;
      @(negedge clk);
      check_eq("le_gnt_c", m1_gnt, 1'b1);
      check_eq("le_no_count", dut.lock_cnt_r, 3'd0);
      next_cycle();
      set_m1(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      check_eq("le_lock_clr", dut.lock_r, 1'b0);
      next_cycle();
      set_m0(1'b1, 4'h0, 32'h10, 32'h0);
      set_m1(1'b1, 4'h0, 32'h20, 32'h0, 1'b0);
      @(negedge clk);
      check_eq("le_contend_gnt0", m0_gnt, 1'b1);
      check_eq("le_contend_gnt1", m1_gnt, 1'b0);
      next_cycle();

      // Reset asserted while a read return is pending
      set_m0(1'b0, 4'h0, 32'h0, 32'h0);
      set_m1(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      check_eq("mr_rvalid_before", m0_rvalid, 1'b1);
      check_eq("mr_rdata_before", m0_rdata, 32'hC0DE_0004);
      rst_n = 1'b0;
      #1;
      check_eq("mr_rvalid_drop", m0_rvalid, 1'b0);
      check_eq("mr_rdata_drop", m0_rdata, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
